// File: rtl/prog_loader_pkg.sv
// Shared constants and FSM state encoding for the program RAM loader.
package prog_loader_pkg;

  localparam int DATA_W = 9;
  localparam int ADDR_W = 5;
  localparam int DEPTH  = 32;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    LOAD = 2'd1,
    DONE = 2'd2
  } state_t;

endpackage

// File: rtl/prog_ram.sv
// Simple dual-port program RAM: one write port and one registered read port.
// A read and a write to the same address in one cycle return the old word.
module prog_ram
  import prog_loader_pkg::*;
(
  input  logic              clk,
  input  logic              rst,
  input  logic              we,
  input  logic [ADDR_W-1:0] waddr,
  input  logic [DATA_W-1:0] wdata,
  input  logic [ADDR_W-1:0] raddr,
  output logic [DATA_W-1:0] rdata
);

  logic [DATA_W-1:0] mem [DEPTH];

  // Storage is deliberately not reset so it maps onto plain RAM.
  always_ff @(posedge clk) begin
    if (we) mem[waddr] <= wdata;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) rdata <= '0;
    else     rdata <= mem[raddr];
  end

endmodule

// File: rtl/prog_ram_loader.sv
// Loads a stream of instruction words into the program RAM from address 0
// while the fetch side keeps reading it through a registered port.
module prog_ram_loader
  import prog_loader_pkg::*;
(
  input  logic              clk,
  input  logic              rst,
  input  logic              load_start,
  input  logic              wr_valid,
  output logic              wr_ready,
  input  logic [DATA_W-1:0] wr_data,
  input  logic              wr_last,
  input  logic [ADDR_W-1:0] rd_addr,
  output logic [DATA_W-1:0] rd_data,
  output logic              busy,
  output logic              load_done,
  output logic [ADDR_W:0]   words_loaded,
  output logic              truncated,
  output state_t            state_dbg
);

  state_t            state;
  logic [ADDR_W-1:0] wptr;
  logic              hs;

  // Handshake: a word transfers on a clock edge where wr_valid & wr_ready.
  // wr_ready depends only on state and load_start, never on wr_valid; the
  // source must hold wr_data/wr_last stable while wr_valid waits for ready.
  assign wr_ready  = (state == LOAD) && !load_start;
  assign hs        = wr_valid && wr_ready;
  assign busy      = (state == LOAD);
  assign load_done = (state == DONE);
  assign state_dbg = state;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state        <= IDLE;
      wptr         <= '0;
      words_loaded <= '0;
      truncated    <= 1'b0;
    end else begin
      case (state)
        IDLE, DONE: begin
          if (load_start) begin
            state        <= LOAD;
            wptr         <= '0;
            words_loaded <= '0;
            truncated    <= 1'b0;
          end
        end
        LOAD: begin
          if (load_start) begin
            wptr         <= '0;
            words_loaded <= '0;
          end else if (hs) begin
            words_loaded <= words_loaded + (ADDR_W+1)'(1);
            // The pointer parks on the last word rather than wrapping.
            if (wr_last) begin
              state <= DONE;
            end else if (wptr == ADDR_W'(DEPTH-1)) begin
              state     <= DONE;
              truncated <= 1'b1;
            end else begin
              wptr <= wptr + ADDR_W'(1);
            end
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  prog_ram u_ram (
    .clk   (clk),
    .rst   (rst),
    .we    (hs),
    .waddr (wptr),
    .wdata (wr_data),
    .raddr (rd_addr),
    .rdata (rd_data)
  );

endmodule
